// File: rtl/obf_seq_pkg.sv
// Shared widths, opcode constants and state encoding for the obfuscation
// expansion sequencer.
package obf_seq_pkg;

   localparam int OBF_IGU_WIDTH     = 7;
   localparam int OBF_PPC_WIDTH     = 2;
   localparam int OBF_LUT_OUT_WIDTH = 15;

   localparam logic [5:0] OBF_ALU_OPC      = 6'h38;
   localparam int         OBF_ALU_IDX_BASE = 64;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } seq_state_e;

endpackage

// File: rtl/obf_seq_igu.sv
// Index generation: maps the held opcode (and ALU sub-op nibble) to a LUT group.
// A disabled instruction always selects group 0, the single-entry pass-through.
module obf_seq_igu
   import obf_seq_pkg::*;
#(
   parameter int IGU_W = OBF_IGU_WIDTH
) (
   input  logic [5:0]       held_opc,
   input  logic [3:0]       held_sub,
   input  logic             held_en,
   output logic [IGU_W-1:0] lut_index
);

   always_comb begin
      lut_index = '0;
      if (held_en) begin
         if (held_opc == OBF_ALU_OPC)
            lut_index = IGU_W'(OBF_ALU_IDX_BASE) + IGU_W'(held_sub);
         else
            lut_index = IGU_W'(held_opc);
      end
   end

endmodule

// File: rtl/obf_seq.sv
// Expansion sequencer: holds one fetched instruction and steps the pseudo-PC
// through its LUT group, stalling fetch until the last template is consumed.
//
//   state  | meaning
//   -------+-------------------------------------------------
//   IDLE   | nothing held, ready to accept an instruction
//   EXPAND | instruction held, ppc stepping through its group
module obf_seq
   import obf_seq_pkg::*;
#(
   parameter int IGU_W = OBF_IGU_WIDTH,
   parameter int PPC_W = OBF_PPC_WIDTH,
   parameter int LUT_W = OBF_LUT_OUT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             obf_en,
   input  logic             flush,
   input  logic             insn_valid,
   input  logic [31:0]      insn,
   output logic             insn_ready,
   output logic [IGU_W-1:0] lut_index,
   output logic [PPC_W-1:0] lut_ppc,
   input  logic [LUT_W-1:0] lut_sub,
   output logic             out_valid,
   output logic [LUT_W-1:0] out_tmpl,
   output logic [31:0]      out_orig,
   output logic             out_last,
   input  logic             out_ready
);

   seq_state_e       state, state_nxt;
   logic [31:0]      held_insn, held_insn_nxt;
   logic             held_en, held_en_nxt;
   logic [PPC_W-1:0] ppc, ppc_nxt;
   logic             accept, consume;

   obf_seq_igu #(.IGU_W(IGU_W)) u_igu (
      .held_opc  (held_insn[31:26]),
      .held_sub  (held_insn[3:0]),
      .held_en   (held_en),
      .lut_index (lut_index)
   );

   // A group that never flags last is cut off when ppc saturates.
   assign out_last   = lut_sub[0] | (&ppc);
   assign out_valid  = (state == EXPAND) & ~flush;
   assign consume    = out_valid & out_ready;
   assign insn_ready = ~flush & ((state == IDLE) | (consume & out_last));
   assign accept     = insn_valid & insn_ready;

   assign lut_ppc  = ppc;
   assign out_tmpl = lut_sub;
   assign out_orig = held_insn;

   always_comb begin
      state_nxt     = state;
      ppc_nxt       = ppc;
      held_insn_nxt = held_insn;
      held_en_nxt   = held_en;
      if (flush) begin
         state_nxt = IDLE;
         ppc_nxt   = '0;
      end else if (accept) begin
         state_nxt     = EXPAND;
         held_insn_nxt = insn;
         held_en_nxt   = obf_en;
         ppc_nxt       = '0;
      end else if (consume) begin
         if (out_last) begin
            state_nxt = IDLE;
            ppc_nxt   = '0;
         end else begin
            ppc_nxt = ppc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ppc       <= '0;
         held_insn <= '0;
         held_en   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ppc       <= ppc_nxt;
         held_insn <= held_insn_nxt;
         held_en   <= held_en_nxt;
      end
   end

endmodule

// File: tb/tb_obf_seq.sv
// Directed bench for obf_seq with a small behavioural stand-in for obf_lut.
module tb_obf_seq;

   localparam logic [31:0] ADD  = 32'hE063_2000;  // l.add, group 64 (3 entries)
   localparam logic [31:0] ALU1 = 32'hE063_2001;  // group 65, never flags last
   localparam logic [31:0] LWZ  = 32'h8464_0004;  // l.lwz, group 33 (2 entries)

   logic        clk, rst_n, obf_en, flush, insn_valid, insn_ready;
   logic [31:0] insn, out_orig;
   logic [6:0]  lut_index;
   logic [1:0]  lut_ppc;
   logic [14:0] lut_sub, out_tmpl;
   logic        out_valid, out_last, out_ready;

   int n_vec = 0;
   int n_bad = 0;

   obf_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .obf_en     (obf_en),
      .flush      (flush),
      .insn_valid (insn_valid),
      .insn       (insn),
      .insn_ready (insn_ready),
      .lut_index  (lut_index),
      .lut_ppc    (lut_ppc),
      .lut_sub    (lut_sub),
      .out_valid  (out_valid),
      .out_tmpl   (out_tmpl),
      .out_orig   (out_orig),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   // LUT stand-in: group 0 single entry, group 64 three entries, group 65 none
   // flagged last, every other group two entries.
   function automatic logic [14:0] lut_fn(input logic [6:0] idx, input logic [1:0] p);
      logic last;
      if (idx == 7'd0)       last = 1'b1;
      else if (idx == 7'd64) last = (p == 2'd2);
      else if (idx == 7'd65) last = 1'b0;
      else                   last = (p == 2'd1);
      return {2'b01, idx, p, 3'b000, last};
   endfunction

   always_comb lut_sub = lut_fn(lut_index, lut_ppc);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] in;
      logic        en;
      logic        fl;
      logic        ordy;
      logic        e_ready;
      logic        e_valid;
      logic [6:0]  e_idx;
      logic [1:0]  e_ppc;
      logic        e_last;
      logic [31:0] e_orig;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(input logic iv, input logic [31:0] in, input logic en,
                               input logic fl, input logic ordy, input logic e_ready,
                               input logic e_valid, input logic [6:0] e_idx,
                               input logic [1:0] e_ppc, input logic e_last,
                               input logic [31:0] e_orig);
      vec_t v;
      v.iv = iv; v.in = in; v.en = en; v.fl = fl; v.ordy = ordy;
      v.e_ready = e_ready; v.e_valid = e_valid; v.e_idx = e_idx;
      v.e_ppc = e_ppc; v.e_last = e_last; v.e_orig = e_orig;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] in, input logic en,
                        input logic fl, input logic ordy);
      insn_valid = iv; insn = in; obf_en = en; flush = fl; out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, '0, 0, 0, 1);

      vecs[0]  = mk(0, 0,    0, 0, 1,  1, 0, 0,  0, 1, 0);
      vecs[1]  = mk(1, ADD,  1, 0, 1,  1, 0, 0,  0, 1, 0);
      vecs[2]  = mk(0, 0,    1, 0, 1,  0, 1, 64, 0, 0, ADD);
      vecs[3]  = mk(0, 0,    1, 0, 1,  0, 1, 64, 1, 0, ADD);
      vecs[4]  = mk(0, 0,    1, 0, 1,  1, 1, 64, 2, 1, ADD);
      vecs[5]  = mk(0, 0,    0, 0, 1,  1, 0, 64, 0, 0, ADD);
      vecs[6]  = mk(1, ADD,  0, 0, 1,  1, 0, 64, 0, 0, ADD);
      vecs[7]  = mk(0, 0,    0, 0, 1,  1, 1, 0,  0, 1, ADD);
      vecs[8]  = mk(1, ADD,  1, 0, 1,  1, 0, 0,  0, 1, ADD);
      vecs[9]  = mk(1, ADD,  1, 0, 1,  0, 1, 64, 0, 0, ADD);
      vecs[10] = mk(1, ADD,  0, 0, 1,  0, 1, 64, 1, 0, ADD);
      vecs[11] = mk(1, ADD,  1, 0, 1,  1, 1, 64, 2, 1, ADD);
      vecs[12] = mk(0, 0,    0, 0, 1,  0, 1, 64, 0, 0, ADD);
      vecs[13] = mk(0, 0,    0, 0, 1,  0, 1, 64, 1, 0, ADD);
      vecs[14] = mk(0, 0,    0, 0, 1,  1, 1, 64, 2, 1, ADD);
      vecs[15] = mk(1, ALU1, 1, 0, 1,  1, 0, 64, 0, 0, ADD);
      vecs[16] = mk(0, 0,    0, 0, 1,  0, 1, 65, 0, 0, ALU1);
      vecs[17] = mk(0, 0,    0, 0, 1,  0, 1, 65, 1, 0, ALU1);
      vecs[18] = mk(0, 0,    0, 0, 1,  0, 1, 65, 2, 0, ALU1);
      vecs[19] = mk(0, 0,    0, 0, 1,  1, 1, 65, 3, 1, ALU1);
      vecs[20] = mk(1, LWZ,  1, 0, 1,  1, 0, 65, 0, 0, ALU1);
      vecs[21] = mk(0, 0,    0, 0, 1,  0, 1, 33, 0, 0, LWZ);
      vecs[22] = mk(0, 0,    0, 0, 1,  1, 1, 33, 1, 1, LWZ);
      vecs[23] = mk(1, ADD,  1, 1, 1,  0, 0, 33, 0, 0, LWZ);
      vecs[24] = mk(0, 0,    1, 0, 1,  1, 0, 33, 0, 0, LWZ);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].iv, vecs[i].in, vecs[i].en, vecs[i].fl, vecs[i].ordy);
         #3;
         chk($sformatf("v%0d insn_ready", i), 32'(insn_ready), 32'(vecs[i].e_ready));
         chk($sformatf("v%0d out_valid", i),  32'(out_valid),  32'(vecs[i].e_valid));
         chk($sformatf("v%0d lut_index", i),  32'(lut_index),  32'(vecs[i].e_idx));
         chk($sformatf("v%0d lut_ppc", i),    32'(lut_ppc),    32'(vecs[i].e_ppc));
         chk($sformatf("v%0d out_last", i),   32'(out_last),   32'(vecs[i].e_last));
         chk($sformatf("v%0d out_orig", i),   out_orig,        vecs[i].e_orig);
         chk($sformatf("v%0d out_tmpl", i),   32'(out_tmpl),
             32'(lut_fn(vecs[i].e_idx, vecs[i].e_ppc)));
         step();
      end

      // out_ready stall at ppc=1
      drive(1, ADD, 1, 0, 1); step();
      drive(0, '0, 1, 0, 1);  step();
      drive(0, '0, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #3;
         chk("stall ppc",   32'(lut_ppc),   32'd1);
         chk("stall tmpl",  32'(out_tmpl),  32'(lut_fn(7'd64, 2'd1)));
         chk("stall orig",  out_orig,       ADD);
         chk("stall valid", 32'(out_valid), 32'd1);
         chk("stall ready", 32'(insn_ready), 32'd0);
         step();
      end
      drive(0, '0, 1, 0, 1); #3;
      chk("resume ppc", 32'(lut_ppc), 32'd1);
      step(); #3;
      chk("resume ppc2",  32'(lut_ppc),  32'd2);
      chk("resume last",  32'(out_last), 32'd1);
      step();

      // flush at ppc=1 with a pending instruction
      drive(1, ADD, 1, 0, 1); step();
      drive(0, '0, 1, 0, 1);  step();
      drive(1, LWZ, 1, 1, 1); #3;
      chk("flush ppc",   32'(lut_ppc),    32'd1);
      chk("flush valid", 32'(out_valid),  32'd0);
      chk("flush ready", 32'(insn_ready), 32'd0);
      step();
      drive(1, LWZ, 1, 0, 1); #3;
      chk("post-flush valid", 32'(out_valid),  32'd0);
      chk("post-flush ready", 32'(insn_ready), 32'd1);
      chk("post-flush ppc",   32'(lut_ppc),    32'd0);
      step();
      drive(0, '0, 1, 0, 1); #3;
      chk("refetch valid", 32'(out_valid), 32'd1);
      chk("refetch index", 32'(lut_index), 32'd33);
      chk("refetch orig",  out_orig,       LWZ);
      step(); #3;
      chk("refetch last", 32'(out_last), 32'd1);
      step();

      // asynchronous reset mid-EXPAND
      drive(1, ADD, 1, 0, 1); step();
      drive(0, '0, 1, 0, 1);  step(); #3;
      chk("pre-reset ppc", 32'(lut_ppc), 32'd1);
      rst_n = 1'b0; #1;
      chk("reset valid", 32'(out_valid),  32'd0);
      chk("reset ppc",   32'(lut_ppc),    32'd0);
      chk("reset index", 32'(lut_index),  32'd0);
      chk("reset orig",  out_orig,        32'd0);
      chk("reset ready", 32'(insn_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step(); #3;
      chk("after reset valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
